// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller and its datapath/memory.
// master = controller side, slave = datapath + unified memory side.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       OpCode;
    logic [5:0]       func;
    logic             zero;
    logic             overflow;
    logic             mem_ready;

    logic             mem_req;
    logic             MemWrite;
    logic             IRWrite;
    logic             PCWrite;
    logic [2:0]       npc_src;
    logic             RegWrite;
    logic [1:0]       RegDst;
    logic [1:0]       WbSel;
    logic             ALUSrc;
    logic [2:0]       ALUop;
    logic [1:0]       Extop;
    logic             EPCWrite;
    logic [1:0]       exc_code;
    logic             mem_timeout;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        input  OpCode, func, zero, overflow, mem_ready,
        output mem_req, MemWrite, IRWrite, PCWrite, npc_src, RegWrite, RegDst,
               WbSel, ALUSrc, ALUop, Extop, EPCWrite, exc_code, mem_timeout,
               state, retired
    );

    modport slave (
        output OpCode, func, zero, overflow, mem_ready,
        input  mem_req, MemWrite, IRWrite, PCWrite, npc_src, RegWrite, RegDst,
               WbSel, ALUSrc, ALUop, Extop, EPCWrite, exc_code, mem_timeout,
               state, retired
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle IF/ID/EXE/MEM/WB control FSM for the MIPS-subset core with memory
// handshake, retire counter and timeout. Define MC_EXCEPTION_EN to enable traps.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);

`ifdef MC_EXCEPTION_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_EXC = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [1:0]       exc_code_q, exc_code_d;

    logic is_r, is_add, is_addu, is_sub, is_subu, is_slt, is_jr;
    logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, is_addi;
    logic is_valid, ovf_op;

    assign is_r    = (bus.OpCode == 6'b000000);
    assign is_add  = is_r && (bus.func == 6'b100000);
    assign is_addu = is_r && (bus.func == 6'b100001);
    assign is_sub  = is_r && (bus.func == 6'b100010);
    assign is_subu = is_r && (bus.func == 6'b100011);
    assign is_slt  = is_r && (bus.func == 6'b101010);
    assign is_jr   = is_r && (bus.func == 6'b001000);
    assign is_ori  = (bus.OpCode == 6'b001101);
    assign is_lui  = (bus.OpCode == 6'b001111);
    assign is_lw   = (bus.OpCode == 6'b100011);
    assign is_sw   = (bus.OpCode == 6'b101011);
    assign is_beq  = (bus.OpCode == 6'b000100);
    assign is_j    = (bus.OpCode == 6'b000010);
    assign is_jal  = (bus.OpCode == 6'b000011);
    assign is_addi = (bus.OpCode == 6'b001000);

    assign is_valid = is_add | is_addu | is_sub | is_subu | is_slt | is_jr |
                      is_ori | is_lui | is_lw | is_sw | is_beq | is_j | is_jal | is_addi;
    assign ovf_op   = is_add | is_sub | is_addi;

    logic       mem_req, mem_write, ir_write, pc_write, reg_write;
    logic       alu_src, epc_write, waiting, to_expire;
    logic [2:0] npc_src, alu_op;
    logic [1:0] reg_dst, wb_sel, ext_op;

    // Expiry is judged in the same cycle as mem_ready, so a late ready still wins.
    assign waiting   = ((state_q == S_IF) || (state_q == S_MEM)) && !bus.mem_ready;
    assign to_expire = waiting && (to_cnt_q == TO_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        exc_code_d = exc_code_q;
        retired_d  = retired_q;
        to_cnt_d   = (waiting && !to_expire) ? to_cnt_q + TO_W'(1) : '0;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        npc_src    = 3'd0;
        reg_write  = 1'b0;
        reg_dst    = 2'd0;
        wb_sel     = 2'd0;
        alu_src    = 1'b0;
        alu_op     = 3'd0;
        ext_op     = 2'd0;
        epc_write  = 1'b0;

        case (state_q)
            S_IF: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_ID;
                end else if (EXC_EN && to_expire) begin
                    state_d    = S_EXC;
                    exc_code_d = 2'd2;
                end
            end
            S_ID: begin
                if (is_j) begin
                    pc_write = 1'b1;
                    npc_src  = 3'd2;
                    state_d  = S_IF;
                end else if (is_jal) begin
                    pc_write  = 1'b1;
                    npc_src   = 3'd2;
                    reg_write = 1'b1;
                    reg_dst   = 2'd2;
                    wb_sel    = 2'd2;
                    state_d   = S_IF;
                end else if (!is_valid) begin
                    if (EXC_EN) begin
                        state_d    = S_EXC;
                        exc_code_d = 2'd3;
                    end else begin
                        state_d = S_IF;
                    end
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                alu_src = !is_r && !is_beq;
                if (is_ori)                           ext_op = 2'd0;
                else if (is_lui)                      ext_op = 2'd2;
                else                                  ext_op = 2'd1;
                if (is_sub || is_subu || is_beq)      alu_op = 3'd1;
                else if (is_slt)                      alu_op = 3'd3;
                else if (is_ori)                      alu_op = 3'd2;
                else if (is_lui)                      alu_op = 3'd4;
                else                                  alu_op = 3'd0;

                if (is_beq) begin
                    pc_write = bus.zero;
                    npc_src  = 3'd1;
                    state_d  = S_IF;
                end else if (is_jr) begin
                    pc_write = 1'b1;
                    npc_src  = 3'd3;
                    state_d  = S_IF;
                end else if (EXC_EN && ovf_op && bus.overflow) begin
                    state_d    = S_EXC;
                    exc_code_d = 2'd1;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_write = is_sw;
                if (bus.mem_ready) begin
                    state_d = is_sw ? S_IF : S_WB;
                end else if (EXC_EN && to_expire) begin
                    state_d    = S_EXC;
                    exc_code_d = 2'd2;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                reg_dst   = is_r ? 2'd1 : 2'd0;
                wb_sel    = is_lw ? 2'd1 : 2'd0;
                state_d   = S_IF;
            end
            S_EXC: begin
                epc_write = 1'b1;
                pc_write  = 1'b1;
                npc_src   = 3'd4;
                state_d   = S_IF;
            end
            default: state_d = S_IF;
        endcase

        // Exception entry/exit does not retire an instruction.
        if ((state_q != S_IF) && (state_q != S_EXC) && (state_d == S_IF))
            retired_d = retired_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IF;
            to_cnt_q   <= '0;
            retired_q  <= '0;
            exc_code_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            to_cnt_q   <= to_cnt_d;
            retired_q  <= retired_d;
            exc_code_q <= exc_code_d;
        end
    end

    // Strobes are forced low combinationally so nothing fires while reset is held.
    assign bus.mem_req     = mem_req   && !reset;
    assign bus.MemWrite    = mem_write && !reset;
    assign bus.IRWrite     = ir_write  && !reset;
    assign bus.PCWrite     = pc_write  && !reset;
    assign bus.RegWrite    = reg_write && !reset;
    assign bus.ALUSrc      = alu_src   && !reset;
    assign bus.EPCWrite    = epc_write && !reset;
    assign bus.mem_timeout = to_expire && !reset;
    assign bus.npc_src     = reset ? 3'd0 : npc_src;
    assign bus.ALUop       = reset ? 3'd0 : alu_op;
    assign bus.RegDst      = reset ? 2'd0 : reg_dst;
    assign bus.WbSel       = reset ? 2'd0 : wb_sel;
    assign bus.Extop       = reset ? 2'd0 : ext_op;
    assign bus.exc_code    = EXC_EN ? exc_code_q : 2'd0;
    assign bus.state       = state_q;
    assign bus.retired     = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; covers both builds (MC_EXCEPTION_EN on/off).
module tb_multicycle_ctrl;

    logic        clk;
    logic        reset;
    int          pass_cnt;
    int          total_cnt;
    int          cyc;
    logic [31:0] exp_ret;

    multicycle_ctrl_if #(.CNT_W(32)) bus ();

    multicycle_ctrl #(
        .MEM_TIMEOUT(16),
        .TO_W       (5),
        .CNT_W      (32)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        #2;
        total_cnt++;
        if ({bus.state, bus.mem_req, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite,
             bus.EPCWrite, bus.mem_timeout, bus.npc_src, bus.exc_code} !== 15'd0)
            $display("FAIL reset_state: got state=%0d mem_req=%b PCWrite=%b exc=%0d expected all 0",
                     bus.state, bus.mem_req, bus.PCWrite, bus.exc_code);
        else pass_cnt++;
        total_cnt++;
        if (bus.retired !== 32'd0)
            $display("FAIL reset_retired: got %0d expected 0", bus.retired);
        else pass_cnt++;
        step();
        step();
        total_cnt++;
        if ({bus.state, bus.mem_req, bus.IRWrite} !== 5'd0)
            $display("FAIL reset_held: got state=%0d mem_req=%b expected 0 0", bus.state, bus.mem_req);
        else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++;
        if ({bus.state, bus.mem_req} !== 4'b000_1)
            $display("FAIL reset_release: got state=%0d mem_req=%b expected 0 1", bus.state, bus.mem_req);
        else pass_cnt++;
        $display("reset: state=%0d retired=%0d", bus.state, bus.retired);
    endtask

    task automatic test_rtype();
        int start;
        bus.OpCode = 6'b000000;
        bus.func   = 6'b100001;
        #1;
        start = cyc;
        total_cnt++;
        if ({bus.IRWrite, bus.PCWrite, bus.npc_src, bus.mem_req} !== 6'b11_000_1)
            $display("FAIL addu_if: got IRWrite=%b PCWrite=%b npc=%0d expected 1 1 0",
                     bus.IRWrite, bus.PCWrite, bus.npc_src);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.state !== 3'd1) $display("FAIL addu_id: got state %0d expected 1", bus.state);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({bus.state, bus.ALUSrc, bus.ALUop} !== 7'b010_0_000)
            $display("FAIL addu_exe: got state=%0d ALUSrc=%b ALUop=%0d expected 2 0 0",
                     bus.state, bus.ALUSrc, bus.ALUop);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({bus.state, bus.RegWrite, bus.RegDst, bus.WbSel} !== 8'b100_1_01_00)
            $display("FAIL addu_wb: got state=%0d RegWrite=%b RegDst=%0d WbSel=%0d expected 4 1 1 0",
                     bus.state, bus.RegWrite, bus.RegDst, bus.WbSel);
        else pass_cnt++;
        step();
        exp_ret++;
        total_cnt++;
        if (bus.state !== 3'd0 || bus.retired !== exp_ret || (cyc - start) != 4)
            $display("FAIL addu_done: got state=%0d retired=%0d cycles=%0d expected 0 %0d 4",
                     bus.state, bus.retired, cyc - start, exp_ret);
        else pass_cnt++;
        $display("addu: cycles=%0d retired=%0d", cyc - start, bus.retired);
    endtask

    task automatic test_lw();
        int start;
        bus.OpCode = 6'b100011;
        bus.mem_ready = 1'b1;
        #1;
        start = cyc;
        step();
        step();
        total_cnt++;
        if ({bus.state, bus.ALUSrc, bus.Extop, bus.ALUop} !== 9'b010_1_01_000)
            $display("FAIL lw_exe: got state=%0d ALUSrc=%b Extop=%0d ALUop=%0d expected 2 1 1 0",
                     bus.state, bus.ALUSrc, bus.Extop, bus.ALUop);
        else pass_cnt++;
        bus.mem_ready = 1'b0;
        step();
        for (int w = 0; w < 3; w++) begin
            total_cnt++;
            if ({bus.state, bus.mem_req, bus.MemWrite, bus.mem_timeout} !== 6'b011_1_0_0)
                $display("FAIL lw_mem_wait: got state=%0d mem_req=%b MemWrite=%b tmo=%b expected 3 1 0 0",
                         bus.state, bus.mem_req, bus.MemWrite, bus.mem_timeout);
            else pass_cnt++;
            step();
        end
        bus.mem_ready = 1'b1;
        step();
        total_cnt++;
        if ({bus.state, bus.RegWrite, bus.RegDst, bus.WbSel} !== 8'b100_1_00_01)
            $display("FAIL lw_wb: got state=%0d RegWrite=%b RegDst=%0d WbSel=%0d expected 4 1 0 1",
                     bus.state, bus.RegWrite, bus.RegDst, bus.WbSel);
        else pass_cnt++;
        step();
        exp_ret++;
        total_cnt++;
        if (bus.state !== 3'd0 || bus.retired !== exp_ret || (cyc - start) != 8)
            $display("FAIL lw_done: got state=%0d retired=%0d cycles=%0d expected 0 %0d 8",
                     bus.state, bus.retired, cyc - start, exp_ret);
        else pass_cnt++;
        $display("lw: cycles=%0d retired=%0d", cyc - start, bus.retired);
    endtask

    task automatic test_beq();
        int start;
        bus.OpCode = 6'b000100;
        for (int z = 1; z >= 0; z--) begin
            bus.zero = z[0];
            #1;
            start = cyc;
            step();
            step();
            total_cnt++;
            if ({bus.state, bus.ALUop, bus.PCWrite, bus.npc_src} !== {3'd2, 3'd1, z[0], 3'd1})
                $display("FAIL beq_exe_z%0d: got state=%0d ALUop=%0d PCWrite=%b npc=%0d expected 2 1 %0d 1",
                         z, bus.state, bus.ALUop, bus.PCWrite, bus.npc_src, z);
            else pass_cnt++;
            step();
            exp_ret++;
            total_cnt++;
            if (bus.state !== 3'd0 || bus.retired !== exp_ret || (cyc - start) != 3)
                $display("FAIL beq_done_z%0d: got state=%0d retired=%0d cycles=%0d expected 0 %0d 3",
                         z, bus.state, bus.retired, cyc - start, exp_ret);
            else pass_cnt++;
            $display("beq zero=%0d: cycles=%0d retired=%0d", z, cyc - start, bus.retired);
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_jal();
        int start;
        bus.OpCode = 6'b000011;
        #1;
        start = cyc;
        step();
        total_cnt++;
        if ({bus.state, bus.PCWrite, bus.npc_src, bus.RegWrite, bus.RegDst, bus.WbSel}
                !== 12'b001_1_010_1_10_10)
            $display("FAIL jal_id: got state=%0d PCWrite=%b npc=%0d RegWrite=%b RegDst=%0d WbSel=%0d expected 1 1 2 1 2 2",
                     bus.state, bus.PCWrite, bus.npc_src, bus.RegWrite, bus.RegDst, bus.WbSel);
        else pass_cnt++;
        step();
        exp_ret++;
        total_cnt++;
        if (bus.state !== 3'd0 || bus.retired !== exp_ret || (cyc - start) != 2)
            $display("FAIL jal_done: got state=%0d retired=%0d cycles=%0d expected 0 %0d 2",
                     bus.state, bus.retired, cyc - start, exp_ret);
        else pass_cnt++;
        $display("jal: cycles=%0d retired=%0d", cyc - start, bus.retired);
    endtask

    task automatic test_ori_sw();
        int start;
        bus.OpCode = 6'b001101;
        #1;
        start = cyc;
        step();
        step();
        total_cnt++;
        if ({bus.Extop, bus.ALUop, bus.ALUSrc} !== 6'b00_010_1)
            $display("FAIL ori_exe: got Extop=%0d ALUop=%0d ALUSrc=%b expected 0 2 1",
                     bus.Extop, bus.ALUop, bus.ALUSrc);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({bus.state, bus.RegWrite, bus.RegDst, bus.WbSel} !== 8'b100_1_00_00)
            $display("FAIL ori_wb: got state=%0d RegWrite=%b RegDst=%0d expected 4 1 0",
                     bus.state, bus.RegWrite, bus.RegDst);
        else pass_cnt++;
        step();
        exp_ret++;
        $display("ori: cycles=%0d retired=%0d", cyc - start, bus.retired);

        bus.OpCode = 6'b101011;
        #1;
        start = cyc;
        step();
        step();
        step();
        total_cnt++;
        if ({bus.state, bus.mem_req, bus.MemWrite, bus.RegWrite} !== 6'b011_1_1_0)
            $display("FAIL sw_mem: got state=%0d mem_req=%b MemWrite=%b RegWrite=%b expected 3 1 1 0",
                     bus.state, bus.mem_req, bus.MemWrite, bus.RegWrite);
        else pass_cnt++;
        step();
        exp_ret++;
        total_cnt++;
        if (bus.state !== 3'd0 || bus.retired !== exp_ret || (cyc - start) != 4)
            $display("FAIL sw_done: got state=%0d retired=%0d cycles=%0d expected 0 %0d 4",
                     bus.state, bus.retired, cyc - start, exp_ret);
        else pass_cnt++;
        $display("sw: cycles=%0d retired=%0d", cyc - start, bus.retired);
    endtask

    task automatic test_overflow();
        bus.OpCode   = 6'b000000;
        bus.func     = 6'b100000;
        bus.overflow = 1'b1;
        #1;
        step();
        step();
        step();
`ifdef MC_EXCEPTION_EN
        total_cnt++;
        if ({bus.state, bus.RegWrite, bus.exc_code, bus.npc_src, bus.EPCWrite, bus.PCWrite}
                !== 11'b101_0_01_100_1_1)
            $display("FAIL add_ovf_exc: got state=%0d RegWrite=%b exc=%0d npc=%0d EPCWrite=%b expected 5 0 1 4 1",
                     bus.state, bus.RegWrite, bus.exc_code, bus.npc_src, bus.EPCWrite);
        else pass_cnt++;
        step();
`else
        total_cnt++;
        if ({bus.state, bus.RegWrite, bus.RegDst, bus.exc_code} !== 8'b100_1_01_00)
            $display("FAIL add_ovf_wb: got state=%0d RegWrite=%b RegDst=%0d exc=%0d expected 4 1 1 0",
                     bus.state, bus.RegWrite, bus.RegDst, bus.exc_code);
        else pass_cnt++;
        step();
        exp_ret++;
`endif
        bus.overflow = 1'b0;
        total_cnt++;
        if (bus.state !== 3'd0 || bus.retired !== exp_ret)
            $display("FAIL add_ovf_done: got state=%0d retired=%0d expected 0 %0d",
                     bus.state, bus.retired, exp_ret);
        else pass_cnt++;
        $display("add overflow: exc_code=%0d retired=%0d", bus.exc_code, bus.retired);
    endtask

    task automatic test_reserved();
        int start;
        bus.OpCode = 6'b111111;
        #1;
        start = cyc;
        step();
        step();
`ifdef MC_EXCEPTION_EN
        total_cnt++;
        if ({bus.state, bus.exc_code, bus.EPCWrite, bus.npc_src} !== 9'b101_11_1_100)
            $display("FAIL reserved_exc: got state=%0d exc=%0d EPCWrite=%b npc=%0d expected 5 3 1 4",
                     bus.state, bus.exc_code, bus.EPCWrite, bus.npc_src);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.state !== 3'd0 || bus.exc_code !== 2'd3 || bus.retired !== exp_ret)
            $display("FAIL reserved_done: got state=%0d exc=%0d retired=%0d expected 0 3 %0d",
                     bus.state, bus.exc_code, bus.retired, exp_ret);
        else pass_cnt++;
`else
        exp_ret++;
        total_cnt++;
        if (bus.state !== 3'd0 || bus.retired !== exp_ret || (cyc - start) != 2 || bus.EPCWrite !== 1'b0)
            $display("FAIL reserved_nop: got state=%0d retired=%0d cycles=%0d expected 0 %0d 2",
                     bus.state, bus.retired, cyc - start, exp_ret);
        else pass_cnt++;
`endif
        $display("reserved: cycles=%0d retired=%0d", cyc - start, bus.retired);
    endtask

    task automatic test_timeout();
        bus.OpCode    = 6'b000010;
        bus.mem_ready = 1'b0;
        #1;
        for (int w = 1; w <= 16; w++) begin
            total_cnt++;
            if ({bus.state, bus.mem_timeout} !== {3'd0, (w == 16)})
                $display("FAIL timeout_wait%0d: got state=%0d tmo=%b expected 0 %0d",
                         w, bus.state, bus.mem_timeout, (w == 16));
            else pass_cnt++;
            step();
        end
`ifdef MC_EXCEPTION_EN
        total_cnt++;
        if ({bus.state, bus.exc_code, bus.EPCWrite, bus.PCWrite, bus.npc_src} !== 10'b101_10_1_1_100)
            $display("FAIL timeout_exc: got state=%0d exc=%0d EPCWrite=%b npc=%0d expected 5 2 1 4",
                     bus.state, bus.exc_code, bus.EPCWrite, bus.npc_src);
        else pass_cnt++;
        step();
`endif
        total_cnt++;
        if ({bus.state, bus.mem_req, bus.mem_timeout} !== 5'b000_1_0)
            $display("FAIL timeout_retry: got state=%0d mem_req=%b tmo=%b expected 0 1 0",
                     bus.state, bus.mem_req, bus.mem_timeout);
        else pass_cnt++;
        repeat (15) step();
        bus.mem_ready = 1'b1;
        #1;
        total_cnt++;
        if ({bus.state, bus.mem_timeout, bus.IRWrite} !== 5'b000_0_1)
            $display("FAIL timeout_ready_wins: got state=%0d tmo=%b IRWrite=%b expected 0 0 1",
                     bus.state, bus.mem_timeout, bus.IRWrite);
        else pass_cnt++;
        step();
        step();
        exp_ret++;
        total_cnt++;
        if (bus.state !== 3'd0 || bus.retired !== exp_ret)
            $display("FAIL timeout_j_done: got state=%0d retired=%0d expected 0 %0d",
                     bus.state, bus.retired, exp_ret);
        else pass_cnt++;
        $display("timeout: exc_code=%0d retired=%0d", bus.exc_code, bus.retired);
    endtask

    task automatic test_reset_mid();
        bus.OpCode    = 6'b101011;
        bus.mem_ready = 1'b1;
        #1;
        step();
        step();
        bus.mem_ready = 1'b0;
        step();
        total_cnt++;
        if ({bus.state, bus.MemWrite} !== 4'b011_1)
            $display("FAIL rstmid_pre: got state=%0d MemWrite=%b expected 3 1", bus.state, bus.MemWrite);
        else pass_cnt++;
        #2;
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({bus.state, bus.mem_req, bus.MemWrite, bus.PCWrite, bus.IRWrite, bus.RegWrite,
             bus.EPCWrite, bus.mem_timeout, bus.exc_code} !== 12'd0 || bus.retired !== 32'd0)
            $display("FAIL rstmid_assert: got state=%0d mem_req=%b MemWrite=%b retired=%0d exc=%0d expected 0 0 0 0 0",
                     bus.state, bus.mem_req, bus.MemWrite, bus.retired, bus.exc_code);
        else pass_cnt++;
        step();
        reset = 1'b0;
        exp_ret = 32'd0;
        #1;
        total_cnt++;
        if ({bus.state, bus.mem_req, bus.MemWrite, bus.RegWrite} !== 6'b000_1_0_0 || bus.retired !== exp_ret)
            $display("FAIL rstmid_release: got state=%0d mem_req=%b MemWrite=%b retired=%0d expected 0 1 0 0",
                     bus.state, bus.mem_req, bus.MemWrite, bus.retired);
        else pass_cnt++;
        $display("reset mid sw: state=%0d retired=%0d", bus.state, bus.retired);
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        cyc           = 0;
        exp_ret       = 32'd0;
        reset         = 1'b0;
        bus.OpCode    = 6'd0;
        bus.func      = 6'd0;
        bus.zero      = 1'b0;
        bus.overflow  = 1'b0;
        bus.mem_ready = 1'b1;

        test_reset();
        test_rtype();
        test_lw();
        test_beq();
        test_jal();
        test_ori_sw();
        test_overflow();
        test_reserved();
        test_timeout();
        test_reset_mid();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
